// File: rtl/pmt_pulse_conditioner_if.sv
// pmt_pulse_conditioner_if: PMT input/phase and event/statistics bundle for pmt_pulse_conditioner.
interface pmt_pulse_conditioner_if;
    logic        PMT_in;
    logic        enable;
    logic [31:0] phase_in;
    logic        event_valid;
    logic [31:0] event_phase;
    logic [31:0] event_count;
    logic [31:0] glitch_count;
    logic [31:0] deadtime_reject_count;
    modport master (
        output PMT_in, enable, phase_in,
        input  event_valid, event_phase, event_count, glitch_count, deadtime_reject_count
    );
    modport slave (
        input  PMT_in, enable, phase_in,
        output event_valid, event_phase, event_count, glitch_count, deadtime_reject_count
    );
endinterface

// File: rtl/pmt_pulse_conditioner.sv
// pmt_pulse_conditioner: synchronises a PMT discriminator, width-qualifies pulses, applies dead time and timestamps events.
// Define PMT_PULSE_STATS_EN to build the glitch and dead-time reject counters; otherwise those outputs read 0.
module pmt_pulse_conditioner #(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_WIDTH   = 2,
    parameter int DEAD_TIME   = 10
) (
    input logic                     clock_50_mhz,
    input logic                     reset,
    pmt_pulse_conditioner_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, QUALIFY, DEAD} state_t;
    state_t                 r_state, w_next;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_sync_d, w_sync_q, w_rise, w_start, w_fire;
    logic [31:0]            r_width, r_dead, r_pending, r_event_phase, r_event_count;
    logic                   r_event_valid;
    assign w_sync_q = r_sync[SYNC_STAGES-1];
    assign w_rise   = w_sync_q & ~r_sync_d;
    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        w_fire  = 1'b0;
        if (!bus.enable)
            w_next = IDLE;
        else
            case (r_state)
                IDLE: begin
                    w_start = w_rise;
                    w_next  = w_rise ? QUALIFY : IDLE;
                end
                QUALIFY: begin
                    w_fire = w_sync_q && r_width == 32'(MIN_WIDTH);
                    w_next = !w_sync_q ? IDLE : w_fire ? DEAD : QUALIFY;
                end
                DEAD:    w_next = r_dead == 32'(DEAD_TIME - 1) ? IDLE : DEAD;
                default: w_next = IDLE;
            endcase
    end
    always_ff @(posedge clock_50_mhz) begin
        if (reset) begin
            r_sync        <= '0;
            r_sync_d      <= 1'b0;
            r_state       <= IDLE;
            r_width       <= '0;
            r_dead        <= '0;
            r_pending     <= '0;
            r_event_valid <= 1'b0;
            r_event_phase <= '0;
            r_event_count <= '0;
        end else begin
            r_sync        <= {r_sync[SYNC_STAGES-2:0], bus.PMT_in};
            r_sync_d      <= w_sync_q;
            r_state       <= w_next;
            r_event_valid <= w_fire;
            r_dead        <= (r_state == DEAD && w_next == DEAD) ? r_dead + 32'd1 : '0;
            if (w_start) begin
                r_pending <= bus.phase_in;
                r_width   <= 32'd1;
            end else if (r_state == QUALIFY && r_width < 32'(MIN_WIDTH)) begin
                r_width <= r_width + 32'd1;
            end
            if (w_fire) begin
                r_event_phase <= r_pending;
                r_event_count <= r_event_count + {31'd0, r_event_count != '1};
            end
        end
    end
    assign bus.event_valid = r_event_valid;
    assign bus.event_phase = r_event_phase;
    assign bus.event_count = r_event_count;
`ifdef PMT_PULSE_STATS_EN
    logic        w_glitch, w_reject;
    logic [31:0] r_glitch_count, r_reject_count;
    assign w_glitch = bus.enable && r_state == QUALIFY && !w_sync_q;
    assign w_reject = bus.enable && r_state == DEAD && w_rise;
    always_ff @(posedge clock_50_mhz) begin
        if (reset) begin
            r_glitch_count <= '0;
            r_reject_count <= '0;
        end else begin
            r_glitch_count <= r_glitch_count + {31'd0, w_glitch && r_glitch_count != '1};
            r_reject_count <= r_reject_count + {31'd0, w_reject && r_reject_count != '1};
        end
    end
    assign bus.glitch_count          = r_glitch_count;
    assign bus.deadtime_reject_count = r_reject_count;
`else
    assign bus.glitch_count          = '0;
    assign bus.deadtime_reject_count = '0;
`endif
endmodule
